// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared widths and field positions for the FP add/sub datapath.
package fpaddsub_pkg;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int SUM_W = MANT_W + 5;
  localparam int LZC_W = $clog2(SUM_W);
  localparam int CARRY_BIT = SUM_W - 1;
  localparam int HIDDEN_BIT = SUM_W - 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
endpackage

// File: rtl/fpaddsub_lzc.sv
// fpaddsub_lzc: combinational priority leading-zero counter with all-zero flag.
module fpaddsub_lzc import fpaddsub_pkg::*; #(
  parameter int W = HIDDEN_BIT + 1,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count,
  output logic          all_zero
);
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) if (vec[i]) count = CW'(W - 1 - i);
  end
  assign all_zero = ~|vec;
endmodule

// File: rtl/fpaddsub_normalize_pipe.sv
// fpaddsub_normalize_pipe: two-stage normalizer turning the raw adder sum into a normalized mantissa and exponent.
module fpaddsub_normalize_pipe import fpaddsub_pkg::*; #(
  parameter int EXP_W = fpaddsub_pkg::EXP_W,
  parameter int MANT_W = fpaddsub_pkg::MANT_W,
  parameter int SUM_W = fpaddsub_pkg::SUM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [SUM_W-1:0]    sum_in,
  input  logic [EXP_W-1:0]    cexp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_out,
  output logic [EXP_W-1:0]    exp_out,
  output logic [MANT_W+2:0]   frac_out,
  output logic                zero_out,
  output logic                ovf_out,
  output logic                unf_out
);
  localparam int LW = $clog2(SUM_W);
  localparam int FW = MANT_W + 3;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  logic s1_valid, s2_valid, adv2, all_zero;
  logic s1_sign, s1_carry, s1_zero;
  logic [EXP_W-1:0] s1_cexp, n_exp;
  logic [SUM_W-1:0] s1_sum;
  logic [LW-1:0] lzc, s1_lzc;
  logic [FW-1:0] n_frac;
  logic n_zero, n_ovf, n_unf;
  logic [EXP_W:0] e_ext, e_inc, lz_ext;
  assign adv2 = !s2_valid || out_ready;
  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign out_valid = s2_valid;
  fpaddsub_lzc #(.W(SUM_W - 1)) u_lzc (
    .vec(sum_in[SUM_W-2:0]),
    .count(lzc),
    .all_zero(all_zero)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_carry <= 1'b0;
      s1_zero <= 1'b0;
      s1_cexp <= '0;
      s1_sum <= '0;
      s1_lzc <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_in;
        s1_carry <= sum_in[SUM_W-1];
        s1_zero <= all_zero && !sum_in[SUM_W-1];
        s1_cexp <= cexp_in;
        s1_sum <= sum_in;
        s1_lzc <= lzc;
      end
    end
  end
  // exponent math is done one bit wider so carry/borrow cannot wrap silently
  assign e_ext = {1'b0, s1_cexp};
  assign e_inc = e_ext + 1'b1;
  assign lz_ext = (EXP_W + 1)'(s1_lzc);
  always_comb begin
    n_exp = '0;
    n_frac = '0;
    n_zero = 1'b0;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    if (s1_zero) n_zero = 1'b1;
    else if (s1_carry) begin
      n_ovf = e_inc >= EMAX;
      n_exp = n_ovf ? '1 : e_inc[EXP_W-1:0];
      n_frac = n_ovf ? '0 : (s1_sum[FW:1] | FW'(s1_sum[0]));
    end else if (s1_lzc == '0 || lz_ext < e_ext) begin
      n_exp = EXP_W'(e_ext - lz_ext);
      n_frac = FW'(s1_sum << s1_lzc);
    end else begin
      n_unf = 1'b1;
      n_zero = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      sign_out <= 1'b0;
      exp_out <= '0;
      frac_out <= '0;
      zero_out <= 1'b0;
      ovf_out <= 1'b0;
      unf_out <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sign_out <= s1_sign;
        exp_out <= n_exp;
        frac_out <= n_frac;
        zero_out <= n_zero;
        ovf_out <= n_ovf;
        unf_out <= n_unf;
      end
    end
  end
endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// tb_fpaddsub_normalize_pipe: randomized and directed checks of the normalizer against an arithmetic model.
module tb_fpaddsub_normalize_pipe;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready, sign_in = 1'b0;
  logic out_valid, out_ready = 1'b0, sign_out, zero_out, ovf_out, unf_out;
  logic [14:0] sum_in = '0;
  logic [4:0] cexp_in = '0, exp_out;
  logic [12:0] frac_out;
  logic [21:0] obs;
  int vectors = 0, errors = 0;
  typedef struct {logic s; logic [14:0] sum; logic [4:0] cexp; logic [21:0] want;} beat_t;
  beat_t stim_q[$];
  logic [21:0] exp_q[$];

  fpaddsub_normalize_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .sum_in(sum_in), .cexp_in(cexp_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .exp_out(exp_out), .frac_out(frac_out), .zero_out(zero_out),
    .ovf_out(ovf_out), .unf_out(unf_out)
  );

  assign obs = {sign_out, exp_out, frac_out, zero_out, ovf_out, unf_out};
  always #5 clk = ~clk;

  // result packed as {sign, exp[4:0], frac[12:0], zero, ovf, unf}
  function automatic logic [21:0] model(input logic s, input int sum, input int cexp);
    int p, lz, e, f;
    logic z, o, u;
    e = 0; f = 0; z = 0; o = 0; u = 0;
    if (sum == 0) z = 1;
    else if (sum >= 16384) begin
      if (cexp + 1 >= 31) begin o = 1; e = 31; end
      else begin e = cexp + 1; f = ((sum >> 1) | (sum & 1)) % 8192; end
    end else begin
      p = 0;
      while ((sum >> (p + 1)) != 0) p++;
      lz = 13 - p;
      if (lz == 0 || lz < cexp) begin e = cexp - lz; f = (sum << lz) % 8192; end
      else begin u = 1; z = 1; end
    end
    return {s, 5'(e), 13'(f), z, o, u};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int k;
    k = $urandom_range(3);
    b.s = 1'($urandom_range(1));
    b.cexp = 5'($urandom_range(31));
    b.sum = k == 0 ? 15'($urandom) : k == 1 ? 15'((1 << $urandom_range(13)) | $urandom_range(3))
          : k == 2 ? 15'(0) : 15'(16384 | $urandom_range(16383));
    b.want = model(b.s, int'(b.sum), int'(b.cexp));
    return b;
  endfunction

  task automatic add_beat(input logic s, input logic [14:0] sum, input logic [4:0] cexp, input logic [21:0] want);
    beat_t b;
    b.s = s; b.sum = sum; b.cexp = cexp; b.want = want;
    stim_q.push_back(b);
  endtask

  task automatic run_beats(input string name, input int hold, input int rdy_pct,
                           output int early_acc, output int first_out, output int last_out);
    int n, sent, got, cyc;
    logic held, acc_in, acc_out;
    logic [21:0] held_val, want;
    n = stim_q.size(); sent = 0; got = 0; cyc = 0; held = 0; held_val = '0;
    early_acc = 0; first_out = -1; last_out = -1;
    exp_q.delete();
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      in_valid = sent < n;
      if (sent < n) begin
        sign_in = stim_q[sent].s; sum_in = stim_q[sent].sum; cexp_in = stim_q[sent].cexp;
      end
      out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      #1;
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || obs !== held_val) begin
          errors++;
          $display("FAIL %s hold_stable cyc %0d: got valid %b %h, want valid 1 %h", name, cyc, out_valid, obs, held_val);
        end
      end
      held = out_valid && !out_ready;
      held_val = obs;
      acc_in = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        vectors++;
        want = exp_q.size() > 0 ? exp_q.pop_front() : 22'bx;
        if (obs !== want) begin
          errors++;
          $display("FAIL %s result %0d: got %h, want %h", name, got, obs, want);
        end
        got++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (acc_in) begin
        exp_q.push_back(stim_q[sent].want);
        sent++;
        if (cyc < hold) early_acc++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (got != n) begin
      errors++;
      $display("FAIL %s count: got %0d results, want %0d (cycle budget)", name, got, n);
    end
    repeat (3) begin
      @(negedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s extra_beat: got out_valid %b, want 0", name, out_valid);
      end
    end
    stim_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; sum_in = 15'h4001; cexp_in = 5'd15; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({out_valid, obs} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b %h, want 0 0", out_valid, obs);
    end
    rst = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid %b, want 0", out_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || obs !== {1'b0, 5'd16, 13'h0001, 3'b000}) begin
      errors++;
      $display("FAIL latency_beat: got valid %b %h, want valid 1 %h", out_valid, obs, {1'b0, 5'd16, 13'h0001, 3'b000});
    end
    @(negedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_drain: got out_valid %b, want 0", out_valid);
    end
  endtask

  task automatic test_carry();
    int ea, f, l;
    add_beat(1'b0, 15'h4001, 5'd15, {1'b0, 5'd16, 13'h0001, 3'b000});
    add_beat(1'b1, 15'h7FFF, 5'd4, {1'b1, 5'd5, 13'h1FFF, 3'b000});
    run_beats("carry", 0, 100, ea, f, l);
  endtask

  task automatic test_shift();
    int ea, f, l;
    add_beat(1'b0, 15'h0400, 5'd10, {1'b0, 5'd7, 13'h0000, 3'b000});
    add_beat(1'b0, 15'h2008, 5'd10, {1'b0, 5'd10, 13'h0008, 3'b000});
    add_beat(1'b1, 15'h0003, 5'd20, {1'b1, 5'd8, 13'h1000, 3'b000});
    run_beats("shift", 0, 100, ea, f, l);
  endtask

  task automatic test_boundaries();
    int ea, f, l;
    add_beat(1'b0, 15'h0400, 5'd3, {1'b0, 5'd0, 13'h0000, 3'b101});
    add_beat(1'b1, 15'h0000, 5'd7, {1'b1, 5'd0, 13'h0000, 3'b100});
    add_beat(1'b0, 15'h4000, 5'd30, {1'b0, 5'd31, 13'h0000, 3'b010});
    add_beat(1'b0, 15'h0400, 5'd4, {1'b0, 5'd1, 13'h0000, 3'b000});
    add_beat(1'b0, 15'h2001, 5'd0, {1'b0, 5'd0, 13'h0001, 3'b000});
    run_beats("boundary", 0, 100, ea, f, l);
  endtask

  task automatic test_backpressure();
    int ea, f, l;
    repeat (5) stim_q.push_back(rand_beat());
    run_beats("backpressure", 4, 100, ea, f, l);
    vectors++;
    if (ea !== 2) begin
      errors++;
      $display("FAIL backpressure_accepts: got %0d accepts while stalled, want 2", ea);
    end
    vectors++;
    if (f !== 4 || l !== 8) begin
      errors++;
      $display("FAIL backpressure_drain: got outputs cycles %0d..%0d, want 4..8", f, l);
    end
  endtask

  task automatic test_back_to_back();
    int ea, f, l;
    repeat (30) stim_q.push_back(rand_beat());
    run_beats("back_to_back", 0, 100, ea, f, l);
    vectors++;
    if (l - f !== 29) begin
      errors++;
      $display("FAIL back_to_back_rate: got span %0d cycles, want 29", l - f);
    end
  endtask

  task automatic test_random();
    int ea, f, l;
    repeat (300) stim_q.push_back(rand_beat());
    run_beats("random", 0, 65, ea, f, l);
  endtask

  task automatic test_reset_midflight();
    logic seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sum_in = 15'h2008; cexp_in = 5'd10;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midflight_fill: got out_valid %b, want 1", out_valid);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || obs !== 22'd0) begin
      errors++;
      $display("FAIL midflight_async: got valid %b %h, want 0 0", out_valid, obs);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      seen |= out_valid;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midflight_stale: got out_valid 1 after reset, want 0");
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_shift();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
